mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_IF_WAIT, default 4, the number of consecutive data-port grants allowed while fetch waits before fetch is forced (range 1-15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port if_request, input, 1, fetch port request; held high with if_addr stable until if_valid.
REQ-005 SHALL have port if_addr, input, 32, fetch address.
REQ-006 SHALL have ports if_rdata (output, 32, fetched word) and if_valid (output, 1, one-cycle completion pulse).
REQ-007 SHALL have port dm_request, input, 1, memory-stage request (load|store); held high with all dm_* fields stable until dm_valid.
REQ-008 SHALL have ports dm_we_re (input, 1, 1=store), dm_mask (input, 4, byte mask), dm_addr (input, 32) and dm_wdata (input, 32, store data).
REQ-009 SHALL have ports dm_rdata (output, 32, load word) and dm_valid (output, 1, one-cycle completion pulse).
REQ-010 SHALL have ports mem_request, mem_we_re, mem_mask[3:0], mem_addr[31:0] and mem_wdata[31:0], all outputs, forming the shared memory command.
REQ-011 SHALL have ports mem_rdata (input, 32) and mem_data_valid (input, 1), the memory response.
REQ-012 SHALL have ports stall_if and stall_mem, outputs, 1 each, pipeline stall requests.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY_IF, BUSY_DM.
REQ-014 In IDLE, a port is eligible when its request is high and its own valid pulse is low in that cycle.
REQ-015 In IDLE with only one eligible port, SHALL grant it and move to BUSY_IF or BUSY_DM next cycle.
REQ-016 In IDLE with both eligible, SHALL grant data unless starve_cnt == MAX_IF_WAIT, in which case it SHALL grant fetch.
REQ-017 starve_cnt (4-bit) SHALL increment, saturating at MAX_IF_WAIT, on each data grant made while fetch is eligible, and SHALL clear on every fetch grant.
REQ-018 On grant, SHALL register the granted port's address, and for data also we_re, mask and wdata; for fetch, mem_we_re=0 and mem_mask=4'b1111.
REQ-019 In BUSY_*, mem_request SHALL be 1 and the mem_* command fields SHALL be driven from the registers, constant until completion; in IDLE, mem_request SHALL be 0.
REQ-020 In BUSY_* with mem_data_valid=1, SHALL return to IDLE next cycle and pulse the owner's valid for exactly that next cycle.
REQ-021 In that completion, SHALL capture mem_rdata into if_rdata (BUSY_IF) or into dm_rdata (BUSY_DM load); for a store, dm_rdata SHALL remain unchanged.
REQ-022 if_rdata and dm_rdata SHALL hold their values until the next capture.
REQ-023 Grant latency SHALL be 1 cycle from an eligible request in IDLE to mem_request=1.
REQ-024 Minimum transaction time SHALL be 3 cycles (request to valid pulse) with zero-wait memory; a new grant SHALL be possible in the valid-pulse cycle.
REQ-025 SHALL ignore mem_data_valid while in IDLE.
REQ-026 stall_if SHALL be if_request & ~if_valid, and stall_mem SHALL be dm_request & ~dm_valid, both combinational.
REQ-027 A request dropped mid-transaction is a protocol violation; the arbiter SHALL still complete the transaction and pulse valid.

Reset
REQ-028 On rst=0, SHALL immediately force IDLE, starve_cnt=0, if_valid=0, dm_valid=0, mem_request=0, mem_we_re=0, mem_mask=0, mem_addr=0, mem_wdata=0, if_rdata=0 and dm_rdata=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no valid pulse; after rst=1, the first eligible request SHALL be granted 1 cycle later.

Verification
REQ-030 Single fetch: if_addr=0x100, memory responds with 2 wait cycles and rdata 0xDEADBEEF -> mem_addr=0x100, mem_mask=0xF, one if_valid pulse, if_rdata=0xDEADBEEF, stall_if high until the pulse.
REQ-031 Simultaneous requests: dm store (addr 0x2000, mask 0x3, data 0x1234) plus fetch -> data is served first (mem_we_re=1, mem_mask=0x3), then fetch; dm_rdata unchanged.
REQ-032 Starvation: dm_request held continuously with back-to-back loads while fetch waits, MAX_IF_WAIT=4 -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
REQ-033 Re-grant guard: a single load completes while dm_request is still high in the dm_valid cycle -> no second data grant is issued in that cycle.
REQ-034 Reset mid-BUSY_DM with mem_data_valid arriving after reset -> no dm_valid, all outputs 0, FSM remains IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-outstanding memory port between an instruction-fetch
//   port and a data (load/store) port. Data normally wins a tie; fetch is
//   forced through once it has lost MAX_IF_WAIT consecutive contests.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_request/if_addr       fetch request and address
//   if_rdata/if_valid        fetched word and one-cycle completion pulse
//   dm_request/dm_we_re/     data request, 1=store, byte mask, address,
//   dm_mask/dm_addr/dm_wdata store data
//   dm_rdata/dm_valid        load word and one-cycle completion pulse
//   mem_request/mem_we_re/   shared memory command, held constant while
//   mem_mask/mem_addr/       a transaction is outstanding
//   mem_wdata
//   mem_rdata/mem_data_valid memory response
//   stall_if/stall_mem       combinational pipeline stall requests
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_IF_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_request,
    input  logic        dm_we_re,
    input  logic [3:0]  dm_mask,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_request,
    output logic        mem_we_re,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_data_valid,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;

    localparam logic [3:0] MAX_WAIT = 4'(MAX_IF_WAIT);

    logic [1:0]  state_q,    state_d;
    logic [3:0]  starve_q,   starve_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
    logic        we_q,       we_d;
    logic [3:0]  mask_q,     mask_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    // A port whose valid pulse is high this cycle has just been served; its
    // request is still the old one, so it must not be granted again.
    logic if_elig, dm_elig, force_if, grant_if, grant_dm;

    assign if_elig  = if_request & ~if_valid_q;
    assign dm_elig  = dm_request & ~dm_valid_q;
    assign force_if = if_elig & (starve_q == MAX_WAIT);
    assign grant_dm = (state_q == IDLE) & dm_elig & ~force_if;
    assign grant_if = (state_q == IDLE) & if_elig & ~grant_dm;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d    = state_q;
        starve_d   = starve_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        we_d       = we_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                // mem_data_valid is deliberately not looked at here.
                if (grant_dm) begin
                    state_d = BUSY_DM;
                    we_d    = dm_we_re;
                    mask_d  = dm_mask;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    // Only a contest that fetch lost counts towards starvation.
                    if (if_elig && (starve_q != MAX_WAIT)) begin
                        starve_d = 4'(starve_q + 4'd1);
                    end
                end else if (grant_if) begin
                    state_d  = BUSY_IF;
                    we_d     = 1'b0;
                    mask_d   = 4'b1111;
                    addr_d   = if_addr;
                    starve_d = 4'd0;
                end
            end
            BUSY_IF: begin
                if (mem_data_valid) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_DM: begin
                if (mem_data_valid) begin
                    state_d    = IDLE;
                    dm_valid_d = 1'b1;
                    // A store returns no data; keep the last load word.
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            we_q       <= 1'b0;
            mask_q     <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            we_q       <= we_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_request = (state_q != IDLE);
    assign mem_we_re   = we_q;
    assign mem_mask    = mask_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_valid    = if_valid_q;
    assign dm_valid    = dm_valid_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign stall_if    = if_request & ~if_valid_q;
    assign stall_mem   = dm_request & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter (MAX_IF_WAIT = 4). Inputs change and
//   outputs are sampled on the falling clock edge; the DUT acts on the rising
//   edge. The memory response is driven by hand in each step.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_request;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_request;
    logic        dm_we_re;
    logic [3:0]  dm_mask;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_request;
    logic        mem_we_re;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_data_valid;
    logic        stall_if;
    logic        stall_mem;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MAX_IF_WAIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_request     (if_request),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_valid       (if_valid),
        .dm_request     (dm_request),
        .dm_we_re       (dm_we_re),
        .dm_mask        (dm_mask),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .dm_valid       (dm_valid),
        .mem_request    (mem_request),
        .mem_we_re      (mem_we_re),
        .mem_mask       (mem_mask),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .stall_if       (stall_if),
        .stall_mem      (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst            = 1'b0;
        if_request     = 1'b0;
        if_addr        = 32'd0;
        dm_request     = 1'b0;
        dm_we_re       = 1'b0;
        dm_mask        = 4'd0;
        dm_addr        = 32'd0;
        dm_wdata       = 32'd0;
        mem_rdata      = 32'd0;
        mem_data_valid = 1'b0;

        // ---- reset state ----
        tick();
        check("rst_if_valid",    if_valid,    0);
        check("rst_dm_valid",    dm_valid,    0);
        check("rst_mem_request", mem_request, 0);
        check("rst_mem_we_re",   mem_we_re,   0);
        check("rst_mem_mask",    mem_mask,    0);
        check("rst_mem_addr",    mem_addr,    0);
        check("rst_mem_wdata",   mem_wdata,   0);
        check("rst_if_rdata",    if_rdata,    0);
        check("rst_dm_rdata",    dm_rdata,    0);
        check("rst_stall_if",    stall_if,    0);
        check("rst_stall_mem",   stall_mem,   0);
        rst = 1'b1;
        tick();

        // ---- single fetch, two wait cycles ----
        if_request = 1'b1;
        if_addr    = 32'h100;
        #1;
        check("f1_stall_if_req",  stall_if,    1);
        check("f1_no_grant_yet",  mem_request, 0);
        tick();
        check("f1_mem_request",   mem_request, 1);
        check("f1_mem_addr",      mem_addr,    32'h100);
        check("f1_mem_mask",      mem_mask,    4'hF);
        check("f1_mem_we_re",     mem_we_re,   0);
        check("f1_stall_if_busy", stall_if,    1);
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("f1_wait1_req",     mem_request, 1);
        check("f1_wait1_valid",   if_valid,    0);
        tick();
        check("f1_wait2_req",     mem_request, 1);
        check("f1_wait2_stall",   stall_if,    1);
        mem_data_valid = 1'b1;
        tick();
        check("f1_if_valid",      if_valid,    1);
        check("f1_if_rdata",      if_rdata,    32'hDEADBEEF);
        check("f1_idle",          mem_request, 0);
        check("f1_stall_if_done", stall_if,    0);
        mem_data_valid = 1'b0;
        if_request     = 1'b0;
        tick();
        check("f1_pulse_end",     if_valid,    0);
        check("f1_rdata_hold",    if_rdata,    32'hDEADBEEF);
        check("f1_stay_idle",     mem_request, 0);

        // ---- memory response while idle is ignored ----
        mem_data_valid = 1'b1;
        mem_rdata      = 32'h55555555;
        tick();
        check("idle_mdv_if_valid", if_valid, 0);
        check("idle_mdv_dm_valid", dm_valid, 0);
        check("idle_mdv_if_rdata", if_rdata, 32'hDEADBEEF);
        check("idle_mdv_dm_rdata", dm_rdata, 0);
        mem_data_valid = 1'b0;

        // ---- simultaneous store + fetch: data first ----
        dm_request = 1'b1;
        dm_we_re   = 1'b1;
        dm_mask    = 4'h3;
        dm_addr    = 32'h2000;
        dm_wdata   = 32'h1234;
        if_request = 1'b1;
        if_addr    = 32'h104;
        #1;
        check("s2_stall_mem_req", stall_mem, 1);
        tick();
        check("s2_st_request",    mem_request, 1);
        check("s2_st_we_re",      mem_we_re,   1);
        check("s2_st_mask",       mem_mask,    4'h3);
        check("s2_st_addr",       mem_addr,    32'h2000);
        check("s2_st_wdata",      mem_wdata,   32'h1234);
        mem_data_valid = 1'b1;
        mem_rdata      = 32'hCAFEF00D;
        tick();
        check("s2_dm_valid",      dm_valid,    1);
        check("s2_store_no_rd",   dm_rdata,    0);
        check("s2_stall_mem_end", stall_mem,   0);
        check("s2_idle_gap",      mem_request, 0);
        check("s2_if_not_yet",    if_valid,    0);
        dm_request     = 1'b0;
        dm_we_re       = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        check("s2_f_request",     mem_request, 1);
        check("s2_f_addr",        mem_addr,    32'h104);
        check("s2_f_mask",        mem_mask,    4'hF);
        check("s2_f_we_re",       mem_we_re,   0);
        check("s2_dm_pulse_end",  dm_valid,    0);
        mem_data_valid = 1'b1;
        mem_rdata      = 32'h11112222;
        tick();
        check("s2_if_valid",      if_valid,    1);
        check("s2_if_rdata",      if_rdata,    32'h11112222);
        check("s2_dm_rdata_keep", dm_rdata,    0);
        if_request     = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        check("s2_idle",          mem_request, 0);

        // ---- starvation: data held, fetch raised in each fresh idle cycle ----
        // A fetch request left high through a data valid-pulse cycle would be
        // granted right there, so fetch is lowered once each contest is lost.
        dm_request = 1'b1;
        dm_we_re   = 1'b0;
        dm_mask    = 4'hF;
        if_addr    = 32'h400;
        for (int i = 0; i < 4; i++) begin
            dm_addr    = 32'h3000 + 32'(4 * i);
            if_request = 1'b1;
            tick();
            check("sv_data_wins_addr", mem_addr,  32'h3000 + 32'(4 * i));
            check("sv_data_wins_we",   mem_we_re, 0);
            if_request     = 1'b0;
            mem_data_valid = 1'b1;
            mem_rdata      = 32'hA0 + 32'(i);
            tick();
            check("sv_dm_valid",       dm_valid,  1);
            check("sv_dm_rdata",       dm_rdata,  32'hA0 + 32'(i));
            mem_data_valid = 1'b0;
            tick();
            // dm_request still high during the pulse: no second grant.
            check("sv_no_regrant",     mem_request, 0);
            check("sv_dm_pulse_end",   dm_valid,    0);
        end
        dm_addr    = 32'h3100;
        if_request = 1'b1;
        tick();
        check("sv_fetch_forced_addr", mem_addr,  32'h400);
        check("sv_fetch_forced_mask", mem_mask,  4'hF);
        check("sv_fetch_forced_we",   mem_we_re, 0);
        mem_data_valid = 1'b1;
        mem_rdata      = 32'hF00DF00D;
        tick();
        check("sv_if_valid",          if_valid,  1);
        check("sv_if_rdata",          if_rdata,  32'hF00DF00D);
        if_request     = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        // Data was eligible in the fetch valid-pulse cycle.
        check("sv_data_next_req",     mem_request, 1);
        check("sv_data_next_addr",    mem_addr,    32'h3100);
        mem_data_valid = 1'b1;
        mem_rdata      = 32'hB5;
        tick();
        check("sv_data_next_valid",   dm_valid, 1);
        check("sv_data_next_rdata",   dm_rdata, 32'hB5);
        mem_data_valid = 1'b0;
        dm_addr        = 32'h3104;
        tick();
        // Counter cleared by the fetch grant: data wins a fresh contest.
        if_request = 1'b1;
        tick();
        check("sv_cleared_data_wins", mem_addr,  32'h3104);
        check("sv_cleared_we",        mem_we_re, 0);
        mem_data_valid = 1'b1;
        mem_rdata      = 32'hC6;
        tick();
        check("sv_cleared_valid",     dm_valid, 1);
        check("sv_cleared_rdata",     dm_rdata, 32'hC6);
        if_request     = 1'b0;
        dm_request     = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        check("sv_end_idle",          mem_request, 0);

        // ---- reset in the middle of a data load ----
        dm_request = 1'b1;
        dm_we_re   = 1'b0;
        dm_mask    = 4'hF;
        dm_addr    = 32'h5000;
        tick();
        check("r_busy_req",  mem_request, 1);
        check("r_busy_addr", mem_addr,    32'h5000);
        #2;
        rst = 1'b0;
        #1;
        check("r_async_req",    mem_request, 0);
        check("r_async_addr",   mem_addr,    0);
        check("r_async_mask",   mem_mask,    0);
        check("r_async_we",     mem_we_re,   0);
        check("r_async_wdata",  mem_wdata,   0);
        check("r_async_ifrd",   if_rdata,    0);
        check("r_async_dmrd",   dm_rdata,    0);
        check("r_async_dmval",  dm_valid,    0);
        dm_request     = 1'b0;
        mem_data_valid = 1'b1;
        mem_rdata      = 32'h77;
        tick();
        rst = 1'b1;
        tick();
        check("r_late_mdv_dmval", dm_valid,    0);
        check("r_late_mdv_req",   mem_request, 0);
        check("r_late_mdv_dmrd",  dm_rdata,    0);
        check("r_late_mdv_addr",  mem_addr,    0);
        mem_data_valid = 1'b0;
        if_request     = 1'b1;
        if_addr        = 32'h600;
        tick();
        check("r_first_grant_req",  mem_request, 1);
        check("r_first_grant_addr", mem_addr,    32'h600);
        mem_data_valid = 1'b1;
        mem_rdata      = 32'h00600600;
        tick();
        check("r_first_if_valid",   if_valid, 1);
        check("r_first_if_rdata",   if_rdata, 32'h00600600);
        if_request     = 1'b0;
        mem_data_valid = 1'b0;
        tick();
        check("r_final_idle",       mem_request, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
